// File: rtl/pwm_fade_ctrl_pkg.sv
// Shared definitions for the PWM fade controller: FSM states, defaults and
// the duty ceiling helper.
package pwm_fade_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RAMP  = 2'd1,
    ST_BR_DN = 2'd2,
    ST_BR_UP = 2'd3
  } state_t;

  localparam int unsigned DEF_STEP     = 5;
  localparam int unsigned DEF_RAMP_DIV = 1024;

  // Largest duty value representable in dw bits.
  function automatic int unsigned duty_max(input int unsigned dw);
    return (32'd1 << dw) - 32'd1;
  endfunction

endpackage

// File: rtl/pwm_fade_ctrl_ramp_ticker.sv
// Free-running divider: asserts tick for one cycle every RAMP_DIV cycles.
// The first tick appears RAMP_DIV cycles after reset release.
module ramp_ticker
  import pwm_fade_ctrl_pkg::*;
#(
  parameter int unsigned RAMP_DIV = DEF_RAMP_DIV
) (
  input  logic CLK,
  input  logic RST_N,
  output logic tick
);

  localparam int unsigned CW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(RAMP_DIV - 1);

  logic [CW-1:0] count;

  // Count 0..RAMP_DIV-1 and wrap.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/pwm_fade_ctrl.sv
// Duty sequencer for the 8-bit PWM generator: saturating target from
// up/down strobes, one-LSB-per-tick ramp toward it, optional breathe cycle.
module pwm_fade_ctrl
  import pwm_fade_ctrl_pkg::*;
#(
  parameter int unsigned DW       = 8,
  parameter int unsigned STEP     = DEF_STEP,
  parameter int unsigned RAMP_DIV = DEF_RAMP_DIV
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          up_pulse,
  input  logic          dn_pulse,
  input  logic          breathe,
  output logic [DW-1:0] duty,
  output logic [DW-1:0] target,
  output logic          busy,
  output logic          at_max,
  output logic          at_min
);

  localparam logic [DW-1:0] DUTY_MAX = DW'(duty_max(DW));
  localparam logic [DW:0]   STEP_W   = (DW+1)'(STEP);

  state_t        state;
  logic          tick;
  logic [DW:0]   sum_up;
  logic [DW:0]   diff_dn;
  logic [DW-1:0] target_next;

  ramp_ticker #(.RAMP_DIV(RAMP_DIV)) u_ticker (
    .CLK   (CLK),
    .RST_N (RST_N),
    .tick  (tick)
  );

  // Saturating target arithmetic in DW+1 bits; the extra bit flags overflow
  // on the way up and borrow on the way down.
  always_comb begin
    sum_up      = {1'b0, target} + STEP_W;
    diff_dn     = {1'b0, target} - STEP_W;
    target_next = target;
    if (up_pulse && !dn_pulse) begin
      target_next = (sum_up > {1'b0, DUTY_MAX}) ? DUTY_MAX : sum_up[DW-1:0];
    end else if (dn_pulse && !up_pulse) begin
      target_next = diff_dn[DW] ? '0 : diff_dn[DW-1:0];
    end
  end

  // Target register, updated every cycle regardless of FSM state.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      target <= '0;
    end else begin
      target <= target_next;
    end
  end

  // Fade FSM: transitions are evaluated every cycle and take priority over a
  // duty step; duty only moves on a tick in a cycle with no transition.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= ST_IDLE;
      duty  <= '0;
      busy  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (breathe) begin
            state <= ST_BR_DN;
            busy  <= 1'b1;
          end else if (target != duty) begin
            state <= ST_RAMP;
            busy  <= 1'b1;
          end
        end
        ST_RAMP: begin
          if (breathe) begin
            state <= ST_BR_DN;
          end else if (duty == target) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else if (tick) begin
            duty <= (target > duty) ? duty + DW'(1) : duty - DW'(1);
          end
        end
        ST_BR_DN: begin
          if (!breathe) begin
            state <= ST_RAMP;
          end else if (duty == '0) begin
            state <= ST_BR_UP;
          end else if (tick) begin
            duty <= duty - DW'(1);
          end
        end
        ST_BR_UP: begin
          if (!breathe) begin
            state <= ST_RAMP;
          end else if (duty >= target) begin
            state <= ST_BR_DN;
          end else if (tick) begin
            duty <= duty + DW'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign at_max = (target == DUTY_MAX);
  assign at_min = (target == '0);

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Self-checking bench for pwm_fade_ctrl with a fast ramp (RAMP_DIV=4).
module tb_pwm_fade_ctrl;

  localparam int DW       = 8;
  localparam int STEP     = 5;
  localparam int RAMP_DIV = 4;
  localparam int DMAX     = 255;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          up_pulse = 1'b0;
  logic          dn_pulse = 1'b0;
  logic          breathe = 1'b0;
  logic [DW-1:0] duty;
  logic [DW-1:0] target;
  logic          busy;
  logic          at_max;
  logic          at_min;

  int checks = 0;
  int failures = 0;

  pwm_fade_ctrl #(.DW(DW), .STEP(STEP), .RAMP_DIV(RAMP_DIV)) dut (
    .CLK      (clk),
    .RST_N    (rst_n),
    .up_pulse (up_pulse),
    .dn_pulse (dn_pulse),
    .breathe  (breathe),
    .duty     (duty),
    .target   (target),
    .busy     (busy),
    .at_max   (at_max),
    .at_min   (at_min)
  );

  always #5 clk = ~clk;

  // Reference model: plain integers, mode names as strings.
  int    m_duty = 0;
  int    m_target = 0;
  int    m_cnt = 0;
  string m_mode = "idle";
  int    nt;
  int    nd;
  int    goal;
  string nm;
  bit    tk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_duty = 0; m_target = 0; m_cnt = 0; m_mode = "idle";
    end else begin
      tk    = (m_cnt == RAMP_DIV - 1);
      m_cnt = (m_cnt + 1) % RAMP_DIV;
      nt = m_target;
      if (up_pulse && !dn_pulse)      nt = (m_target + STEP > DMAX) ? DMAX : m_target + STEP;
      else if (dn_pulse && !up_pulse) nt = (m_target - STEP < 0) ? 0 : m_target - STEP;
      nm = m_mode;
      nd = m_duty;
      if (m_mode == "idle") begin
        if (breathe) nm = "down";
        else if (m_target != m_duty) nm = "ramp";
      end
      else if (!breathe && m_mode != "ramp")               nm = "ramp";
      else if (breathe && m_mode == "ramp")                nm = "down";
      else if (m_mode == "ramp" && m_duty == m_target)     nm = "idle";
      else if (m_mode == "down" && m_duty == 0)            nm = "up";
      else if (m_mode == "up" && m_duty >= m_target)       nm = "down";
      else if (tk) begin
        goal = (m_mode == "down") ? 0 : m_target;
        nd   = m_duty + ((goal > m_duty) ? 1 : -1);
      end
      m_target = nt;
      m_duty   = nd;
      m_mode   = nm;
    end
  end

  function automatic logic [18:0] dut_vec();
    return {duty, target, busy, at_max, at_min};
  endfunction

  function automatic logic [18:0] model_vec();
    return {8'(m_duty), 8'(m_target), (m_mode != "idle"), (m_target == DMAX), (m_target == 0)};
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse(input bit up, input bit dn);
    up_pulse = up;
    dn_pulse = dn;
    next_cycle();
    up_pulse = 1'b0;
    dn_pulse = 1'b0;
  endtask

  task automatic do_reset();
    up_pulse = 1'b0; dn_pulse = 1'b0; breathe = 1'b0;
    rst_n = 1'b0;
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    next_cycle();
    checks++;
    if (dut_vec() !== {8'd0, 8'd0, 1'b0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL reset_state got=%h want=%h", dut_vec(), {8'd0, 8'd0, 1'b0, 1'b0, 1'b1});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_ramp_up();
    int prev;
    int reached;
    do_reset();
    repeat (3) begin
      pulse(1'b1, 1'b0);
      checks++;
      if (dut_vec() !== model_vec()) begin
        failures++; $display("FAIL ramp_pulse got=%h want=%h", dut_vec(), model_vec());
      end
    end
    checks++;
    if (target !== 8'd15) begin failures++; $display("FAIL ramp_target got=%0d want=15", target); end
    prev = duty;
    reached = -1;
    for (int i = 0; i < 80 && reached < 0; i++) begin
      next_cycle();
      checks++;
      if (dut_vec() !== model_vec()) begin
        failures++; $display("FAIL ramp_model got=%h want=%h", dut_vec(), model_vec());
      end
      checks++;
      if (int'(duty) != prev && int'(duty) != prev + 1) begin
        failures++; $display("FAIL ramp_monotonic got=%0d prev=%0d", duty, prev);
      end
      prev = duty;
      if (duty == 8'd15) reached = i;
    end
    checks++;
    if (reached < 0 || reached > 60) begin
      failures++; $display("FAIL ramp_latency got=%0d want<=60", reached);
    end else begin
      checks++;
      if (busy !== 1'b1) begin failures++; $display("FAIL ramp_busy_hold got=%b want=1", busy); end
      next_cycle();
      checks++;
      if (busy !== 1'b0) begin failures++; $display("FAIL ramp_busy_fall got=%b want=0", busy); end
    end
  endtask

  task automatic test_saturate();
    do_reset();
    repeat (52) begin
      pulse(1'b1, 1'b0);
      checks++;
      if (dut_vec() !== model_vec()) begin
        failures++; $display("FAIL sat_model got=%h want=%h", dut_vec(), model_vec());
      end
    end
    checks++;
    if (target !== 8'd255 || at_max !== 1'b1 || at_min !== 1'b0) begin
      failures++; $display("FAIL sat_max got=%0d/%b want=255/1", target, at_max);
    end
    repeat (3) pulse(1'b1, 1'b0);
    checks++;
    if (target !== 8'd255) begin failures++; $display("FAIL sat_hold got=%0d want=255", target); end
    pulse(1'b0, 1'b1);
    checks++;
    if (target !== 8'd250 || at_max !== 1'b0) begin
      failures++; $display("FAIL sat_dn got=%0d want=250", target);
    end
  endtask

  task automatic test_both_strobes();
    bit idle;
    repeat (30) pulse(1'b0, 1'b1);
    checks++;
    if (target !== 8'd100) begin failures++; $display("FAIL both_setup got=%0d want=100", target); end
    idle = 1'b0;
    for (int i = 0; i < 1500 && !idle; i++) begin
      next_cycle();
      checks++;
      if (dut_vec() !== model_vec()) begin
        failures++; $display("FAIL both_model got=%h want=%h", dut_vec(), model_vec());
      end
      idle = (busy == 1'b0);
    end
    checks++;
    if (!idle) begin failures++; $display("FAIL both_settle got=busy want=idle"); end
    pulse(1'b1, 1'b1);
    for (int i = 0; i < 12; i++) begin
      next_cycle();
      checks++;
      if (target !== 8'd100 || duty !== 8'd100 || busy !== 1'b0) begin
        failures++; $display("FAIL both_hold got=%0d/%0d/%b want=100/100/0", target, duty, busy);
      end
    end
  endtask

  task automatic test_breathe();
    int  prev;
    bit  falling;
    bit  seen_zero;
    bit  seen_top;
    bit  released;
    bit  idle;
    do_reset();
    pulse(1'b1, 1'b0);
    pulse(1'b1, 1'b0);
    idle = 1'b0;
    for (int i = 0; i < 100 && !idle; i++) begin
      next_cycle();
      idle = (busy == 1'b0 && duty == 8'd10);
    end
    checks++;
    if (!idle) begin failures++; $display("FAIL br_setup got=%0d want=10", duty); end
    breathe = 1'b1;
    prev = duty; falling = 1'b1; seen_zero = 1'b0; seen_top = 1'b0; released = 1'b0;
    for (int i = 0; i < 400 && !released; i++) begin
      next_cycle();
      checks++;
      if (dut_vec() !== model_vec()) begin
        failures++; $display("FAIL br_model got=%h want=%h", dut_vec(), model_vec());
      end
      checks++;
      if (int'(duty) > prev + 1 || int'(duty) < prev - 1 || int'(duty) > 10) begin
        failures++; $display("FAIL br_step got=%0d prev=%0d", duty, prev);
      end
      if (int'(duty) < prev) falling = 1'b1;
      else if (int'(duty) > prev) falling = 1'b0;
      if (duty == 8'd0) seen_zero = 1'b1;
      if (seen_zero && duty == 8'd10) seen_top = 1'b1;
      if (seen_top && falling && duty == 8'd4) begin
        breathe = 1'b0;
        released = 1'b1;
      end
      prev = duty;
    end
    checks++;
    if (!released) begin failures++; $display("FAIL br_cycle got=zero%b/top%b want=11", seen_zero, seen_top); end
    idle = 1'b0;
    for (int i = 0; i < 100 && !idle; i++) begin
      next_cycle();
      checks++;
      if (dut_vec() !== model_vec()) begin
        failures++; $display("FAIL br_exit_model got=%h want=%h", dut_vec(), model_vec());
      end
      idle = (busy == 1'b0);
    end
    checks++;
    if (!idle || duty !== 8'd10) begin
      failures++; $display("FAIL br_exit got=%0d busy=%b want=10 busy=0", duty, busy);
    end
  endtask

  task automatic test_redirect();
    bit hit;
    int prev;
    do_reset();
    repeat (20) pulse(1'b1, 1'b0);
    hit = 1'b0;
    for (int i = 0; i < 300 && !hit; i++) begin
      next_cycle();
      hit = (duty == 8'd40);
    end
    checks++;
    if (!hit) begin failures++; $display("FAIL redir_reach40 got=%0d want=40", duty); end
    repeat (10) pulse(1'b0, 1'b1);
    checks++;
    if (target !== 8'd50) begin failures++; $display("FAIL redir_target got=%0d want=50", target); end
    hit = 1'b0;
    for (int i = 0; i < 300 && !hit; i++) begin
      next_cycle();
      checks++;
      if (dut_vec() !== model_vec() || duty > 8'd50) begin
        failures++; $display("FAIL redir_model got=%h want=%h", dut_vec(), model_vec());
      end
      hit = (busy == 1'b0);
    end
    checks++;
    if (!hit || duty !== 8'd50) begin failures++; $display("FAIL redir_settle got=%0d want=50", duty); end
    repeat (10) pulse(1'b0, 1'b1);
    checks++;
    if (target !== 8'd0 || at_min !== 1'b1) begin
      failures++; $display("FAIL redir_zero got=%0d want=0", target);
    end
    prev = duty;
    hit = 1'b0;
    for (int i = 0; i < 400 && !hit; i++) begin
      next_cycle();
      checks++;
      if (dut_vec() !== model_vec() || int'(duty) > prev) begin
        failures++; $display("FAIL redir_down got=%0d prev=%0d want=%0d", duty, prev, m_duty);
      end
      prev = duty;
      hit = (busy == 1'b0);
    end
    checks++;
    if (!hit || duty !== 8'd0) begin failures++; $display("FAIL redir_floor got=%0d want=0", duty); end
  endtask

  task automatic test_async_reset();
    bit hit;
    do_reset();
    repeat (20) pulse(1'b1, 1'b0);
    hit = 1'b0;
    for (int i = 0; i < 500 && !hit; i++) begin
      next_cycle();
      hit = (duty == 8'd77);
    end
    checks++;
    if (!hit) begin failures++; $display("FAIL arst_reach77 got=%0d want=77", duty); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (dut_vec() !== {8'd0, 8'd0, 1'b0, 1'b0, 1'b1}) begin
      failures++; $display("FAIL arst_immediate got=%h want=%h", dut_vec(), {8'd0, 8'd0, 1'b0, 1'b0, 1'b1});
    end
    @(negedge clk);
    rst_n = 1'b1;
    pulse(1'b1, 1'b0);
    next_cycle();
    next_cycle();
    checks++;
    if (duty !== 8'd0 || target !== 8'd5) begin
      failures++; $display("FAIL arst_tick_early got=%0d/%0d want=0/5", duty, target);
    end
    next_cycle();
    checks++;
    if (duty !== 8'd1) begin failures++; $display("FAIL arst_first_tick got=%0d want=1", duty); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      up_pulse = ($urandom_range(0, 11) == 0);
      dn_pulse = ($urandom_range(0, 13) == 0);
      if ($urandom_range(0, 249) == 0) breathe = ~breathe;
      next_cycle();
      checks++;
      if (dut_vec() !== model_vec()) begin
        failures++; $display("FAIL random_model cyc=%0d got=%h want=%h", i, dut_vec(), model_vec());
      end
    end
    up_pulse = 1'b0; dn_pulse = 1'b0; breathe = 1'b0;
  endtask

  initial begin
    test_reset();
    test_ramp_up();
    test_saturate();
    test_both_strobes();
    test_breathe();
    test_redirect();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
